draw_car: RTL and testbench

Sprite overlay stage sitting directly downstream of the background stage in the VGA pipeline. Takes the background-coloured VGA bus, overlays one player car sprite fetched from an external sprite ROM at a per-frame latched position, and forwards the bus with a fixed 2-cycle latency. Pixels equal to the key colour are transparent. Display is 800x600.

---
 rtl/draw_car.sv | 111 +++++++++++
 tb/tb_draw_car.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/draw_car.sv
// Car sprite overlay for the VGA pipeline; optional DRAW_CAR_COLLISION_EN adds a sticky collision flag.
// Fixed 2-cycle bus latency, no backpressure; the sprite ROM answers one cycle after pixel_addr.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module draw_car #(
  parameter int          CAR_W     = 32,
  parameter int          CAR_H     = 48,
  parameter int          ADDR_W    = 11,
  parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic [`VGA_BUS_SIZE-1:0] vga_in,
  input  logic [10:0]              xpos,
  input  logic [10:0]              ypos,
  input  logic [11:0]              rgb_pixel,
  output logic [ADDR_W-1:0]        pixel_addr,
  output logic [`VGA_BUS_SIZE-1:0] vga_out
`ifdef DRAW_CAR_COLLISION_EN
  ,
  output logic                     collision
`endif
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  vga_t bus_in, bus_s1, bus_s2, bus_out;
  logic [10:0] x_lat, y_lat;
  logic        pos_valid;
  logic        in_box, in_box_s1, in_box_s2;
  logic        frame_start, draw;
  logic [11:0] h12, v12, xl12, yl12, dx, dy;
  logic [ADDR_W-1:0] addr_c;

  assign bus_in      = vga_in;
  assign frame_start = (bus_in.hcount == 11'd0) && (bus_in.vcount == 11'd0);

  always_ff @(posedge pclk) begin
    if (rst) begin
      x_lat     <= '0;
      y_lat     <= '0;
      pos_valid <= 1'b0;
    end else if (frame_start) begin
      x_lat     <= xpos;
      y_lat     <= ypos;
      pos_valid <= 1'b1;
    end
  end

  // 12-bit compare so the right/bottom box edge never wraps back to the left/top.
  assign h12  = {1'b0, bus_in.hcount};
  assign v12  = {1'b0, bus_in.vcount};
  assign xl12 = {1'b0, x_lat};
  assign yl12 = {1'b0, y_lat};
  assign dx   = h12 - xl12;
  assign dy   = v12 - yl12;

  assign in_box = pos_valid
               && (h12 >= xl12) && (h12 < xl12 + 12'(CAR_W))
               && (v12 >= yl12) && (v12 < yl12 + 12'(CAR_H));

  assign addr_c = ADDR_W'(dy) * ADDR_W'(CAR_W) + ADDR_W'(dx);

  always_ff @(posedge pclk) begin
    if (rst) begin
      bus_s1     <= '0;
      in_box_s1  <= 1'b0;
      pixel_addr <= '0;
      bus_s2     <= '0;
      in_box_s2  <= 1'b0;
    end else begin
      bus_s1     <= bus_in;
      in_box_s1  <= in_box;
      pixel_addr <= in_box ? addr_c : '0;
      bus_s2     <= bus_s1;
      in_box_s2  <= in_box_s1;
    end
  end

  // The ROM word for the stage-2 pixel arrives with it, so the rgb select is taken after the register.
  assign draw = in_box_s2 && !bus_s2.hblnk && !bus_s2.vblnk && (rgb_pixel != KEY_COLOR);

  always_comb begin
    bus_out = bus_s2;
    if (draw) bus_out.rgb = rgb_pixel;
  end

  assign vga_out = bus_out;

`ifdef DRAW_CAR_COLLISION_EN
  always_ff @(posedge pclk) begin
    if (rst)
      collision <= 1'b0;
    else if (draw && (bus_s2.rgb == 12'hFFF))
      collision <= 1'b1;
    else if (frame_start)
      collision <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_draw_car.sv
// Directed bench for draw_car: drives single pixels, checks pixel_addr one cycle later and vga_out two cycles later.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module tb_draw_car;

  logic                     pclk;
  logic                     rst;
  logic [`VGA_BUS_SIZE-1:0] vga_in;
  logic [10:0]              xpos, ypos;
  logic [11:0]              rgb_pixel;
  logic [10:0]              pixel_addr;
  logic [`VGA_BUS_SIZE-1:0] vga_out;
`ifdef DRAW_CAR_COLLISION_EN
  logic                     collision;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int rom_mode = 0;

  localparam logic [11:0] BG  = 12'h123;
  localparam logic [11:0] CAR = 12'h00F;

  draw_car dut (
    .pclk       (pclk),
    .rst        (rst),
    .vga_in     (vga_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .rgb_pixel  (rgb_pixel),
    .pixel_addr (pixel_addr),
    .vga_out    (vga_out)
`ifdef DRAW_CAR_COLLISION_EN
    ,
    .collision  (collision)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Registered sprite ROM: mode 0 is solid car colour, mode 1 keys out the top sprite row.
  always @(posedge pclk) begin
    if (rom_mode == 1 && pixel_addr < 11'd32) rgb_pixel <= 12'h0F0;
    else                                     rgb_pixel <= CAR;
  end

  function automatic logic [`VGA_BUS_SIZE-1:0] pk(input logic [10:0] h, input logic [10:0] v,
                                                  input logic hb, input logic vb, input logic [11:0] rgb);
    return {h, v, h[3], v[2], hb, vb, rgb};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic probe(input string tag, input logic [10:0] h, input logic [10:0] v,
                       input logic hb, input logic vb, input logic [11:0] bg,
                       input logic [11:0] exp_rgb, input logic [10:0] exp_addr);
    vga_in = pk(h, v, hb, vb, bg);
    @(posedge pclk); #1;
    chk({tag, "/addr"}, 64'(pixel_addr), 64'(exp_addr));
    vga_in = pk(11'd900, 11'd650, 1'b1, 1'b1, 12'h000);
    @(posedge pclk); #1;
    chk({tag, "/bus"}, 64'(vga_out), 64'(pk(h, v, hb, vb, exp_rgb)));
  endtask

  initial begin
    rst    = 1'b1;
    xpos   = 11'd100;
    ypos   = 11'd200;
    vga_in = pk(11'd110, 11'd210, 1'b0, 1'b0, BG);
    repeat (3) @(posedge pclk);
    #1;
    chk("reset/bus", 64'(vga_out), 64'd0);
    chk("reset/addr", 64'(pixel_addr), 64'd0);
`ifdef DRAW_CAR_COLLISION_EN
    chk("reset/col", 64'(collision), 64'd0);
`endif
    rst = 1'b0;

    probe("no_latch", 11'd110, 11'd210, 1'b0, 1'b0, BG, BG, 11'd0);
    probe("fs1", 11'd0, 11'd0, 1'b0, 1'b0, BG, BG, 11'd0);

    probe("top_left", 11'd100, 11'd200, 1'b0, 1'b0, BG, CAR, 11'd0);
    probe("bot_right", 11'd131, 11'd247, 1'b0, 1'b0, BG, CAR, 11'd1535);
    probe("middle", 11'd115, 11'd220, 1'b0, 1'b0, BG, CAR, 11'd655);
    probe("left_out", 11'd99, 11'd200, 1'b0, 1'b0, BG, BG, 11'd0);
    probe("right_out", 11'd132, 11'd200, 1'b0, 1'b0, BG, BG, 11'd0);
    probe("above_out", 11'd100, 11'd199, 1'b0, 1'b0, BG, BG, 11'd0);
    probe("below_out", 11'd100, 11'd248, 1'b0, 1'b0, BG, BG, 11'd0);
    probe("hblank", 11'd110, 11'd210, 1'b1, 1'b0, 12'h000, 12'h000, 11'd330);
    probe("vblank", 11'd120, 11'd230, 1'b0, 1'b1, 12'h000, 12'h000, 11'd980);

    rom_mode = 1;
    probe("key_row0", 11'd105, 11'd200, 1'b0, 1'b0, 12'h456, 12'h456, 11'd5);
    probe("key_row1", 11'd105, 11'd201, 1'b0, 1'b0, 12'h456, CAR, 11'd37);
    rom_mode = 0;

    xpos = 11'd300;
    probe("midf_old", 11'd105, 11'd230, 1'b0, 1'b0, BG, CAR, 11'd965);
    probe("midf_new", 11'd305, 11'd230, 1'b0, 1'b0, BG, BG, 11'd0);
    probe("fs2", 11'd0, 11'd0, 1'b0, 1'b0, BG, BG, 11'd0);
    probe("nextf_new", 11'd305, 11'd230, 1'b0, 1'b0, BG, CAR, 11'd965);
    probe("nextf_old", 11'd105, 11'd230, 1'b0, 1'b0, BG, BG, 11'd0);

    xpos = 11'd790;
    ypos = 11'd590;
    probe("fs3", 11'd0, 11'd0, 1'b0, 1'b0, BG, BG, 11'd0);
    probe("edge_0", 11'd790, 11'd590, 1'b0, 1'b0, BG, CAR, 11'd0);
    probe("edge_33", 11'd791, 11'd591, 1'b0, 1'b0, BG, CAR, 11'd33);
    probe("edge_br", 11'd799, 11'd599, 1'b0, 1'b0, BG, CAR, 11'd297);
    probe("nowrap_x", 11'd5, 11'd595, 1'b0, 1'b0, BG, BG, 11'd0);
    probe("nowrap_y", 11'd795, 11'd10, 1'b0, 1'b0, BG, BG, 11'd0);

    xpos = 11'd100;
    ypos = 11'd200;
    probe("fs4", 11'd0, 11'd0, 1'b0, 1'b0, BG, BG, 11'd0);
    probe("pre_rst", 11'd110, 11'd220, 1'b0, 1'b0, BG, CAR, 11'd650);
    vga_in = pk(11'd110, 11'd220, 1'b0, 1'b0, BG);
    rst = 1'b1;
    @(posedge pclk); #1;
    chk("midrst/bus", 64'(vga_out), 64'd0);
    chk("midrst/addr", 64'(pixel_addr), 64'd0);
    rst = 1'b0;
    probe("post_rst", 11'd110, 11'd221, 1'b0, 1'b0, BG, BG, 11'd0);
    probe("fs5", 11'd0, 11'd0, 1'b0, 1'b0, BG, BG, 11'd0);
    probe("reappear", 11'd110, 11'd221, 1'b0, 1'b0, BG, CAR, 11'd682);

`ifdef DRAW_CAR_COLLISION_EN
    chk("col_idle", 64'(collision), 64'd0);
    vga_in = pk(11'd110, 11'd210, 1'b0, 1'b0, 12'hFFF);
    @(posedge pclk); #1;
    vga_in = pk(11'd900, 11'd650, 1'b1, 1'b1, 12'h000);
    @(posedge pclk); #1;
    chk("col_pix/bus", 64'(vga_out), 64'(pk(11'd110, 11'd210, 1'b0, 1'b0, CAR)));
    chk("col_pix/col", 64'(collision), 64'd0);
    @(posedge pclk); #1;
    chk("col_rise", 64'(collision), 64'd1);
    repeat (5) @(posedge pclk);
    #1;
    chk("col_hold", 64'(collision), 64'd1);
    probe("fs6", 11'd0, 11'd0, 1'b0, 1'b0, BG, BG, 11'd0);
    chk("col_clear", 64'(collision), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
